// File: rtl/disp_share_ctrl_if.sv
// Panel-sharing bus: requester inputs, grant and scanned segment outputs.
// master = requester/board side, slave = disp_share_ctrl.
interface disp_share_ctrl_if;
    logic [2:0]  req;
    logic [31:0] digits0;
    logic [31:0] digits1;
    logic [31:0] digits2;
    logic [7:0]  blink0;
    logic [7:0]  blink1;
    logic [7:0]  blink2;
    logic [2:0]  gnt;
    logic [7:0]  seg_data1;
    logic [7:0]  seg_data2;
    logic [7:0]  seg_which;

    modport master (
        output req, digits0, digits1, digits2, blink0, blink1, blink2,
        input  gnt, seg_data1, seg_data2, seg_which
    );

    modport slave (
        input  req, digits0, digits1, digits2, blink0, blink1, blink2,
        output gnt, seg_data1, seg_data2, seg_which
    );
endinterface

// File: rtl/disp_share_ctrl.sv
// Display-sharing controller: fixed-priority panel arbitration and 8-digit BCD scan with blink.
// Define DISP_SHARE_PREEMPT_EN to let a higher request preempt the owner after HOLD cycles.
module disp_share_ctrl #(
    parameter int unsigned SCAN_DIV  = 200000,
    parameter int unsigned HOLD      = 100000000,
    parameter int unsigned BLINK_DIV = 50000000
) (
    input logic              clk,
    input logic              rst,
    disp_share_ctrl_if.slave bus
);
    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1, StOwn2} state_e;

    state_e            state_q, state_d;
    logic [2:0]        gnt_q, gnt_d;
    logic              owner_req, preempt, gnt_change;
    logic [ScanW-1:0]  scan_cnt_q;
    logic [2:0]        slot_q, cap_slot_q;
    logic [3:0]        cap_code_q, slot_nib;
    logic              cap_blank_q, load_q, boundary, slot_blank;
    logic [BlinkW-1:0] blink_cnt_q;
    logic              blink_phase_q;
    logic [31:0]       own_digits;
    logic [7:0]        own_blink;
    logic [7:0]        seg_q, which_q;

    function automatic state_e pick(input logic [2:0] r);
        if (r[2]) return StOwn2;
        if (r[1]) return StOwn1;
        if (r[0]) return StOwn0;
        return StIdle;
    endfunction

    function automatic logic [7:0] seg_lut(input logic [3:0] code);
        case (code)
            4'd0:    return 8'b11111100;
            4'd1:    return 8'b01100000;
            4'd2:    return 8'b11011010;
            4'd3:    return 8'b11110010;
            4'd4:    return 8'b01100110;
            4'd5:    return 8'b10110110;
            4'd6:    return 8'b10111110;
            4'd7:    return 8'b11100000;
            4'd8:    return 8'b11111110;
            4'd9:    return 8'b11110110;
            4'd10:   return 8'b00000010;
            default: return 8'b00000000;
        endcase
    endfunction

`ifdef DISP_SHARE_PREEMPT_EN
    localparam int unsigned HoldW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    logic [HoldW-1:0] hold_cnt_q;
    logic             higher_req;

    always_comb begin
        higher_req = 1'b0;
        unique case (state_q)
            StOwn0:  higher_req = |bus.req[2:1];
            StOwn1:  higher_req = bus.req[2];
            default: higher_req = 1'b0;
        endcase
    end

    assign preempt = higher_req && (hold_cnt_q == HoldW'(HOLD));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q <= '0;
        end else if (gnt_change) begin
            hold_cnt_q <= '0;
        end else if (state_q != StIdle && hold_cnt_q != HoldW'(HOLD)) begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // Losing the owner's request (or an allowed preemption) re-arbitrates from scratch.
    always_comb begin
        state_d   = state_q;
        gnt_d     = 3'b000;
        owner_req = |(bus.req & gnt_q);
        if (!owner_req || preempt) state_d = pick(bus.req);
        unique case (state_d)
            StOwn0:  gnt_d = 3'b001;
            StOwn1:  gnt_d = 3'b010;
            StOwn2:  gnt_d = 3'b100;
            default: gnt_d = 3'b000;
        endcase
    end

    assign gnt_change = (state_d != state_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            gnt_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // A new owner always starts in the visible half of the blink cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (gnt_change) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BlinkW'(1);
        end
    end

    always_comb begin
        own_digits = '0;
        own_blink  = '0;
        unique case (state_q)
            StOwn0:  begin own_digits = bus.digits0; own_blink = bus.blink0; end
            StOwn1:  begin own_digits = bus.digits1; own_blink = bus.blink1; end
            StOwn2:  begin own_digits = bus.digits2; own_blink = bus.blink2; end
            default: ;
        endcase
    end

    // Slot 0 is the leftmost digit: top nibble and top blink bit.
    assign slot_nib   = own_digits[{~slot_q, 2'b00} +: 4];
    assign slot_blank = (state_q == StIdle) || (slot_nib > 4'd10) ||
                        (own_blink[~slot_q] && blink_phase_q);
    assign boundary   = (scan_cnt_q == ScanW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q  <= '0;
            slot_q      <= 3'd0;
            cap_slot_q  <= 3'd0;
            cap_code_q  <= 4'd0;
            cap_blank_q <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            load_q <= boundary;
            if (boundary) begin
                scan_cnt_q  <= '0;
                slot_q      <= slot_q + 3'd1;
                cap_slot_q  <= slot_q;
                cap_code_q  <= slot_nib;
                cap_blank_q <= slot_blank;
            end else begin
                scan_cnt_q <= scan_cnt_q + ScanW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q   <= 8'h00;
            which_q <= 8'h00;
        end else if (load_q) begin
            seg_q   <= cap_blank_q ? 8'h00 : seg_lut(cap_code_q);
            which_q <= cap_blank_q ? 8'h00 : (8'h80 >> cap_slot_q);
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.seg_data1 = seg_q;
    assign bus.seg_data2 = seg_q;
    assign bus.seg_which = which_q;
endmodule

// File: tb/tb_disp_share_ctrl.sv
// Directed bench for disp_share_ctrl with SCAN_DIV=4, HOLD=16, BLINK_DIV=8.
// Edge numbers count rising edges after each reset release (e1 = first).
module tb_disp_share_ctrl;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;

    disp_share_ctrl_if bus ();

    disp_share_ctrl #(
        .SCAN_DIV  (4),
        .HOLD      (16),
        .BLINK_DIV (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef DISP_SHARE_PREEMPT_EN
    localparam logic [2:0] PreemptGnt = 3'b100;
`else
    localparam logic [2:0] PreemptGnt = 3'b001;
`endif

    logic [7:0] exp_seg_b [8] = '{8'hDA, 8'hF2, 8'h02, 8'hB6, 8'hF6, 8'h02, 8'hB6, 8'hF6};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected summary before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic to_edge(input int k);
        while (ecnt < k) begin
            @(posedge clk);
            #1;
            ecnt++;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        ecnt = 0;
    endtask

    task automatic show(input string tag, input logic [7:0] which, input logic [7:0] seg);
        check({tag, "_which"}, bus.seg_which, which);
        check({tag, "_seg1"}, bus.seg_data1, seg);
        check({tag, "_seg2"}, bus.seg_data2, seg);
    endtask

    initial begin
        rst         = 1'b0;
        bus.req     = 3'b000;
        bus.digits0 = 32'h0;
        bus.digits1 = 32'h0;
        bus.digits2 = 32'h0;
        bus.blink0  = 8'h00;
        bus.blink1  = 8'h00;
        bus.blink2  = 8'h00;

        // Reset values, then idle panel stays dark until a request appears
        #12;
        check("rst_gnt", bus.gnt, 3'b000);
        show("rst", 8'h00, 8'h00);
        apply_reset();
        to_edge(5);
        check("idle_gnt", bus.gnt, 3'b000);
        show("idle_slot0", 8'h00, 8'h00);
        bus.digits0 = 32'h23A59A59;
        bus.req     = 3'b001;
        to_edge(6);
        check("late_gnt", bus.gnt, 3'b001);
        to_edge(9);
        show("late_slot1", 8'h40, 8'hF2);

        // Single owner full scan
        apply_reset();
        check("b_gnt_lat", bus.gnt, 3'b000);
        to_edge(1);
        check("b_gnt", bus.gnt, 3'b001);
        for (int s = 0; s < 8; s++) begin
            to_edge(5 + 4 * s);
            show($sformatf("b_slot%0d", s), 8'h80 >> s, exp_seg_b[s]);
        end
        to_edge(36);
        show("b_hold7", 8'h01, 8'hF6);
        to_edge(37);
        show("b_wrap0", 8'h80, 8'hDA);

        // Blank code in slot 4, blink on slots 0-1 while visible
        bus.digits0 = 32'h0123F567;
        bus.blink0  = 8'b11000000;
        apply_reset();
        to_edge(5);
        show("c1_slot0", 8'h80, 8'hFC);
        to_edge(9);
        show("c1_slot1", 8'h40, 8'h60);
        to_edge(21);
        show("c1_slot4", 8'h00, 8'h00);
        to_edge(25);
        show("c1_slot5", 8'h04, 8'hB6);

        // Grant at e24 puts slots 0-1 of the next scan in the dark blink half
        bus.req = 3'b000;
        apply_reset();
        to_edge(23);
        bus.req = 3'b001;
        to_edge(24);
        check("c2_gnt", bus.gnt, 3'b001);
        to_edge(37);
        show("c2_slot0", 8'h00, 8'h00);
        to_edge(41);
        show("c2_slot1", 8'h00, 8'h00);
        to_edge(45);
        show("c2_slot2", 8'h20, 8'hDA);
        to_edge(53);
        show("c2_slot4", 8'h00, 8'h00);

        // Preemption after hold, lower priority never preempts, drop to idle
        bus.blink0 = 8'h00;
        bus.req    = 3'b001;
        apply_reset();
        to_edge(5);
        bus.req = 3'b101;
        to_edge(17);
        check("d_hold_gnt", bus.gnt, 3'b001);
        to_edge(18);
        check("d_preempt_gnt", bus.gnt, PreemptGnt);
        to_edge(20);
        bus.req = 3'b100;
        to_edge(21);
        check("d_drop0_gnt", bus.gnt, 3'b100);
        bus.req = 3'b111;
        to_edge(30);
        check("d_lower_gnt", bus.gnt, 3'b100);
        bus.req = 3'b011;
        to_edge(31);
        check("d_drop2_gnt", bus.gnt, 3'b010);
        bus.req = 3'b000;
        to_edge(32);
        check("d_idle_gnt", bus.gnt, 3'b000);

        // Owner 1 drops while 0 and 2 request; new owner starts visible
        bus.digits0 = 32'h00000000;
        bus.digits1 = 32'h11111111;
        bus.digits2 = 32'h22222222;
        bus.blink1  = 8'hFF;
        bus.blink2  = 8'hFF;
        bus.req     = 3'b010;
        apply_reset();
        to_edge(1);
        check("e_gnt", bus.gnt, 3'b010);
        to_edge(5);
        show("e_slot0", 8'h80, 8'h60);
        to_edge(11);
        show("e_slot1_held", 8'h40, 8'h60);
        to_edge(12);
        bus.req = 3'b101;
        to_edge(13);
        check("e_switch_gnt", bus.gnt, 3'b100);
        show("e_slot2_dark", 8'h00, 8'h00);
        to_edge(14);
        show("e_midslot", 8'h00, 8'h00);
        to_edge(17);
        show("e_slot3_new", 8'h10, 8'hDA);

        // Reset mid-slot clears outputs at once; scan restarts at slot 0
        rst = 1'b0;
        #1;
        check("f_gnt", bus.gnt, 3'b000);
        show("f_async", 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ecnt = 0;
        to_edge(1);
        check("f_regnt", bus.gnt, 3'b100);
        to_edge(5);
        show("f_slot0", 8'h80, 8'hDA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/disp_share_ctrl.md
# disp_share_ctrl

Display-sharing controller for the 8-digit seven-segment panel. Three requesters (time-of-day, stopwatch, alarm) compete for the panel. The block arbitrates ownership with fixed priority and a minimum hold time, then scans the owner's 8 BCD digits onto the shared segment and digit-select lines. Per-digit blinking is applied here. It sits between the timekeeping blocks and the board pins, and replaces per-block scan logic.

## Interface
- SCAN_DIV, 200000: clk cycles per digit slot (2 ms at 100 MHz).
- HOLD, 100000000: minimum cycles an owner keeps the grant before it can be preempted.
- BLINK_DIV, 50000000: clk cycles per blink half-period.

- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- req  in  3  request; [0] time (lowest priority), [1] stopwatch, [2] alarm (highest priority).
- digits0 / digits1 / digits2  in  32 each  packed nibbles for requester 0/1/2; bits [31:28] = leftmost digit (slot 0), bits [3:0] = slot 7.
  - Code 0–9 = numeral, 10 = '-', 11–15 = blank.
- blink0 / blink1 / blink2  in  8 each  per-slot blink mask; bit 7 = slot 0.
- gnt  out  3  registered, one-hot or zero; current owner.
- seg_data1, seg_data2  out  8 each  identical segment codes, bit 7 = segment a … bit 1 = g, bit 0 = dp (always 0).
- seg_which  out  8  one-hot digit select; slot 0 = 8'b10000000, slot 7 = 8'b00000001.

## Operation
- Arbiter states:
  - IDLE: gnt = 0.
  - OWN(k): gnt = one-hot of k.
- IDLE → OWN(highest active req) on the edge after req is sampled non-zero.
- OWN(k):
  - The owner dropping req[k] re-arbitrates that edge: it goes to the highest other active req, else IDLE. This happens regardless of hold.
  - A higher-priority req preempts only when hold_cnt == HOLD (see Configuration).
  - A lower-priority req never preempts.
- hold_cnt:
  - Clears to 0 on every gnt change.
  - Increments each cycle in OWN.
  - Saturates at HOLD.
- Owner dropping its req and a higher req rising in the same cycle: the highest active req is granted.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1; the slot boundary is scan_cnt == SCAN_DIV-1.
  - slot advances 0→7→0 at each boundary and runs continuously, independent of arbitration.
- Per slot, the displayed nibble is the owner's nibble for that slot, sampled at the boundary edge.
- Segment codes: 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110, 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110, '-'=00000010.
- A slot is blanked (seg_which=0, seg_data=0) when any of these holds:
  - gnt == 0;
  - the code is 11–15;
  - the owner's blink bit for that slot = 1 and blink_phase = 1.
- blink_phase:
  - Toggles when blink_cnt reaches BLINK_DIV-1.
  - blink_cnt and blink_phase clear to 0 on every gnt change, so a new owner starts visible.

## Timing
- Reset values: gnt=0, seg_which=0, seg_data1=seg_data2=0; scan_cnt, slot, hold_cnt, blink_cnt and blink_phase all 0; state IDLE.
- Grant latency: req sampled at edge N → gnt valid after edge N+1.
- Display latency: the boundary edge updates slot and captures data; seg_* are registered and valid after the following edge, i.e. 1 cycle after the boundary. They are held for SCAN_DIV cycles.
- A grant change mid-slot does not alter seg_* until the next boundary.
- Reset asserted mid-slot forces all outputs to 0 immediately. Scan restarts at slot 0 after release.

## Configuration
- DISP_SHARE_PREEMPT_EN defined: a higher-priority request preempts the owner once hold_cnt == HOLD. It is granted on the edge after that condition is seen.
- Undefined: no preemption. The owner keeps the panel until it drops req. The hold_cnt logic may be removed.

## Test plan
All scenarios use SCAN_DIV=4, HOLD=16, BLINK_DIV=8.
- Reset: rst low → gnt=000, seg_which=00000000, seg_data1=00000000; after release, slot 0 shows only once a req is present.
- Single owner: req=001, digits0=32'h23A59A59 → gnt=001 next cycle; over 8 slots seg_which walks 10000000…00000001 with seg_data 11011010, 11110010, 00000010, 10110110, …
- Blank code: digits0 nibble 4 = 4'hF → slot 4 has seg_which=00000000 every scan.
- Blink: blink0=8'b11000000 → slots 0–1 visible while blink_phase=0, blanked while phase=1; phase toggles every 8 cycles.
- Preempt (macro defined): owner req=001, req[2] rises at cycle 5 → gnt stays 001 until hold_cnt=16, then 100 the next edge. Without the macro, gnt stays 001 until req[0] drops.
- Drop/simultaneous: owner 010 drops req[1] while req=101 → gnt=100 next edge; blink_phase=0 and hold_cnt=0 at that edge.
